mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

Multi-cycle memory controller that shares the CPU's single byte-wide data RAM between the instruction-fetch port and the load/store port. Each granted 32-bit access is sequenced as four byte beats on the RAM port, little-endian, with per-byte write enables for `sb`/`sh`/`sw`. It sits between the CPU core and the byte-addressed RAM and replaces direct combinational RAM access.

## Interface
- `ADDR_W`, 32: byte address width. Addresses wrap modulo 2^ADDR_W.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held high until `if_done`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_rdata` out 32: fetched word. Valid when `if_done` is high; held until the next `if_done`.
- `if_done` out 1: one-cycle completion pulse.
- `d_req` in 1: load/store request. Held high until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: load/store byte address.
- `d_wdata` in 32: store data.
- `d_be` in 4: store byte enables; bit k covers `d_wdata[8k+7:8k]`. Ignored on loads.
- `d_rdata` out 32: load data. Valid when `d_done` is high; held until the next `d_done`.
- `d_done` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: RAM byte address.
- `mem_re` out 1: RAM read strobe.
- `mem_we` out 1: RAM write strobe.
- `mem_wdata` out 8: RAM write byte.
- `mem_rdata` in 8: RAM read byte. Valid in the cycle after `mem_re`; the RAM read is registered.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, RD (beats 0–3), RWAIT, WR (beats 0–3), DONE.
- **IDLE:**
  - Samples `if_req` and `d_req`.
  - One request pending: that port is granted.
  - Both pending: round-robin; the port not granted last time wins.
  - On grant, latch address, `d_we`, `d_wdata` and `d_be`. Go to RD for fetches and loads, WR for stores.
- **RD beat k:** `mem_re`=1, `mem_addr`=base+k. Byte k is captured from `mem_rdata` one cycle later into bits [8k+7:8k].
- **RWAIT:** captures beat 3.
- **WR beat k:** `mem_addr`=base+k, `mem_wdata`=byte k, `mem_we`=`d_be[k]`.
  - All four beats always run, even when `d_be`=0.
  - `mem_re`=0 throughout.
- **DONE:** pulse the granted port's done, update the stored last grant, return to IDLE.
- Requests are latched at grant. Changes to inputs or a dropped `req` mid-transaction are ignored; the transaction completes.
- A `req` still high in the cycle after `done` is treated as a new request, so requesters must drop it.
- Base address is not aligned. Beat addresses wrap, e.g. 0xFFFFFFFF+1 = 0.
- **Reset values:**
  - Every output is 0 and `if_rdata`/`d_rdata` are 0.
  - State is IDLE; last grant is data, so the fetch port wins the first tie.
- **Reset mid-transaction:**
  - Abort immediately (asynchronous), including deasserting `mem_we`.
  - No done pulse is issued. Bytes already written stay written.

## Timing
- T is the IDLE cycle in which a request is sampled.
- **Read (fetch or load):**
  - Beats on the RAM port in T+1..T+4.
  - Captures at the ends of T+2..T+5.
  - `done` high and `rdata` valid in T+6; IDLE again in T+7.
  - Total 7 cycles per read.
- **Write:** beats in T+1..T+4, `d_done` in T+5, IDLE in T+6. Total 6 cycles.
- `mem_*` outputs are registered from state and beat counter. No combinational path from `mem_rdata` to any output.
- `if_done` and `d_done` are never high in the same cycle.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum `mem_state_e`;
  - port enum `mem_port_e` {PORT_IF, PORT_D};
  - `BEATS`=4;
  - `RESET_LAST_GRANT`=PORT_D.
- Sub-module `mem_rr_arbiter`:
  - 2-way round-robin;
  - inputs: requests, last grant;
  - output: one-hot grant.
- Beat counter: 2 bits, shared by the RD and WR states.

## Test plan
- **Fetch:** RAM[0x10..0x13] = 78 56 34 12; `if_req` with `if_addr`=0x10 → `mem_re` beats at 0x10..0x13 in T+1..T+4, `if_done` in T+6, `if_rdata`=0x12345678.
- **Partial store:** `d_addr`=0x20, `d_wdata`=0xAABBCCDD, `d_be`=4'b0101 over RAM of zeros → `mem_we` only in T+1 (0x20, DD) and T+3 (0x22, BB), `d_done` in T+5; load from 0x20 then returns 0x00BB00DD.
- **Simultaneous requests after reset:** fetch from 0x10 and load from 0x20 → fetch served first, `if_done` in T+6; load granted at T+7, `d_done` in T+13; repeated ties alternate ports.
- **Address wrap:** load from 0xFFFFFFFE → beat addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- **Reset mid-store:** `rst_n` low during T+2 of a 4-byte store → `mem_we` drops immediately, no `d_done`, all outputs 0; after release, a fetch from 0x10 completes normally with 0x12345678.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial memory port controller
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} mem_state_e;
  typedef enum logic {PORT_IF, PORT_D} mem_port_e;
  localparam int BEATS = 4;
  localparam mem_port_e RESET_LAST_GRANT = PORT_D;
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin, one-hot grant (bit 0 fetch, bit 1 data)
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  mem_port_e  last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] && (!req[1] || last == PORT_D);
    gnt[1] = req[1] && !gnt[0];
  end
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: shares one byte-wide RAM between fetch and load/store ports,
// running each 32-bit access as four little-endian byte beats.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  mem_state_e state, state_nx;
  mem_port_e port, last;
  logic [1:0] beat, gnt;
  logic [ADDR_W-1:0] base;
  logic [31:0] wdata;
  logic [3:0] be;
  logic [23:0] rbuf;
  logic last_beat, beating;
  mem_rr_arbiter u_arb (
    .req ({d_req, if_req}),
    .last(last),
    .gnt (gnt)
  );
  assign last_beat = beat == 2'(BEATS - 1);
  assign beating = state == RD || state == WR;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = |gnt ? ((gnt[1] && d_we) ? WR : RD) : IDLE;
      RD:      state_nx = last_beat ? RWAIT : RD;
      RWAIT:   state_nx = DONE;
      WR:      state_nx = last_beat ? DONE : WR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // rbuf shifts every RD cycle; after four shifts it holds bytes 0..2, byte 3 arrives in RWAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      port     <= PORT_IF;
      last     <= RESET_LAST_GRANT;
      beat     <= '0;
      base     <= '0;
      wdata    <= '0;
      be       <= '0;
      rbuf     <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nx;
      beat  <= beating ? beat + 2'd1 : 2'd0;
      if (state == IDLE && |gnt) begin
        port  <= gnt[1] ? PORT_D : PORT_IF;
        base  <= gnt[1] ? d_addr : if_addr;
        wdata <= d_wdata;
        be    <= d_be;
      end
      if (state == RD) rbuf <= {mem_rdata, rbuf[23:8]};
      if (state == RWAIT && port == PORT_IF) if_rdata <= {mem_rdata, rbuf};
      if (state == RWAIT && port == PORT_D) d_rdata <= {mem_rdata, rbuf};
      if (state == DONE) last <= port;
    end
  end
  assign mem_addr  = beating ? base + ADDR_W'(beat) : '0;
  assign mem_re    = state == RD;
  assign mem_we    = state == WR && be[beat];
  assign mem_wdata = state == WR ? wdata[8*beat +: 8] : 8'h00;
  assign if_done   = state == DONE && port == PORT_IF;
  assign d_done    = state == DONE && port == PORT_D;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed scenarios with a cycle-stamped scoreboard of RAM beats and done pulses
module tb_mem_port_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic if_req, if_done, d_req, d_we, d_done, mem_re, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr;
  logic [3:0] d_be;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] ram_q = 8'h00;
  typedef struct {int cyc; logic [31:0] addr; bit re; bit we; logic [7:0] wd;} beat_t;
  typedef struct {int cyc; bit dp; bit chk; logic [31:0] data;} done_t;
  beat_t bq[$];
  done_t dq[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  bit tb_last;
  mem_port_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) ram_q <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = ram_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mon();
    beat_t b;
    done_t d;
    if (bq.size() != 0 && bq[0].cyc == cyc) begin
      b = bq.pop_front();
      chk("mem_re", 32'(mem_re), 32'(b.re));
      chk("mem_we", 32'(mem_we), 32'(b.we));
      chk("mem_addr", mem_addr, b.addr);
      if (b.we) chk("mem_wdata", 32'(mem_wdata), 32'(b.wd));
    end else chk("idle_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    if (dq.size() != 0 && dq[0].cyc == cyc) begin
      d = dq.pop_front();
      chk("done_pair", {30'd0, if_done, d_done}, d.dp ? 32'd1 : 32'd2);
      if (d.chk) chk(d.dp ? "d_rdata" : "if_rdata", d.dp ? d_rdata : if_rdata, d.data);
    end else chk("no_done", {30'd0, if_done, d_done}, 32'd0);
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon();
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_ctl"}, {25'd0, if_done, d_done, mem_re, mem_we, busy, 2'd0}, 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask
  task automatic push_txn(input bit dp, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] data, input int t, output int dc);
    for (int k = 0; k < 4; k++) bq.push_back('{t + 1 + k, a + 32'(k), !we, we && be[k], wd[8*k +: 8]});
    dc = t + (we ? 5 : 6);
    dq.push_back('{dc, dp, !we, data});
  endtask
  task automatic go(input bit f_on, input logic [31:0] fa, input logic [31:0] fexp,
                    input bit d_on, input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                    input logic [3:0] dbe, input logic [31:0] dexp);
    int t, df, dd, endc;
    bit dfirst;
    t = cyc;
    df = -1;
    dd = -1;
    if_req = f_on; if_addr = fa;
    d_req = d_on; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
    dfirst = d_on && (!f_on || !tb_last);
    if (dfirst) begin
      push_txn(1'b1, dwe, da, dwd, dbe, dexp, t, dd);
      if (f_on) push_txn(1'b0, 1'b0, fa, 0, 0, fexp, dd + 1, df);
    end else begin
      push_txn(1'b0, 1'b0, fa, 0, 0, fexp, t, df);
      if (d_on) push_txn(1'b1, dwe, da, dwd, dbe, dexp, df + 1, dd);
    end
    endc = df > dd ? df : dd;
    tb_last = dd > df;
    while (cyc <= endc) begin
      tick();
      if (cyc == t + 1) begin
        chk("busy_active", 32'(busy), 1);
        if (dfirst) begin
          d_addr = ~da; d_wdata = ~dwd; d_be = ~dbe; d_we = !dwe;
        end else if_addr = ~fa;
      end
      if (cyc == df) if_req = 1'b0;
      if (cyc == dd) d_req = 1'b0;
    end
    chk("busy_idle", 32'(busy), 0);
  endtask
  initial begin
    int t;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    tb_last = 1'b1;
    repeat (3) tick();
    zero_chk("reset");
    rst_n = 1'b1;
    tick();
    go(0, 0, 0, 1, 1, 32'h10, 32'h12345678, 4'hF, 0);
    go(1, 32'h10, 32'h12345678, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    go(0, 0, 0, 1, 0, 32'h20, 0, 0, 32'h00BB00DD);
    go(0, 0, 0, 1, 1, 32'hFFFFFFFE, 32'hCAFEF00D, 4'hF, 0);
    go(0, 0, 0, 1, 0, 32'hFFFFFFFE, 0, 0, 32'hCAFEF00D);
    t = cyc;
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h11223344; d_be = 4'hF;
    bq.push_back('{t + 1, 32'h30, 1'b0, 1'b1, 8'h44});
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 zero_chk("abort");
    d_req = 1'b0;
    tick();
    tick();
    chk("ram_kept", 32'(ram[8'h30]), 32'h44);
    chk("ram_unwritten", 32'(ram[8'h31]), 32'h00);
    rst_n = 1'b1;
    tb_last = 1'b1;
    tick();
    go(1, 32'h10, 32'h12345678, 1, 0, 32'h20, 0, 0, 32'h00BB00DD);
    go(1, 32'h20, 32'h00BB00DD, 0, 0, 0, 0, 0, 0);
    go(1, 32'h10, 32'h12345678, 1, 0, 32'hFFFFFFFE, 0, 0, 32'hCAFEF00D);
    go(1, 32'hFFFFFFFE, 32'hCAFEF00D, 1, 1, 32'h40, 32'h55667788, 4'b1110, 0);
    go(0, 0, 0, 1, 0, 32'h40, 0, 0, 32'h55667700);
    chk("beats_drained", 32'(bq.size()), 0);
    chk("dones_drained", 32'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
